// File: rtl/bounce_pkg.sv
// Shared state encoding and default parameter values for the lane bounce engine.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    RISE = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_LANES  = 4;
  localparam int unsigned DEF_POS_W      = 7;
  localparam int unsigned DEF_COLOR_W    = 3;
  localparam int unsigned DEF_SCORE_W    = 16;
  localparam int unsigned DEF_HIT_WIN    = 4;
  localparam int unsigned DEF_FLOOR_Y    = 116;
  localparam int unsigned DEF_START_Y    = 0;
  localparam int unsigned DEF_BOUNCE_LEN = 50;

endpackage

// File: rtl/lane_hit_check.sv
// Single-lane hit test: colours equal and platform inside the ball's catch window.
module lane_hit_check #(
  parameter int unsigned POS_W   = 7,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned HIT_WIN = 4
) (
  input  logic [POS_W-1:0]   ball_y,
  input  logic [COLOR_W-1:0] ball_color,
  input  logic [POS_W-1:0]   plat_pos,
  input  logic [COLOR_W-1:0] plat_color,
  output logic               match_c
);

  localparam int unsigned WIDE_W = POS_W + 1;

  logic [WIDE_W-1:0] win_top;
  logic [WIDE_W-1:0] pos_wide;

  // Window top carries one extra bit so a ball near the top of the range cannot wrap.
  always_comb begin
    win_top  = {1'b0, ball_y} + WIDE_W'(HIT_WIN);
    pos_wide = {1'b0, plat_pos};
    match_c  = (ball_color == plat_color) && (plat_pos >= ball_y) && (pos_wide <= win_top);
  end

endmodule

// File: rtl/lane_bounce_engine.sv
// Frame-stepped ball bounce game: lane key presses catch a falling ball on matching platforms.
module lane_bounce_engine
  import bounce_pkg::*;
#(
  parameter int unsigned NUM_LANES  = DEF_NUM_LANES,
  parameter int unsigned POS_W      = DEF_POS_W,
  parameter int unsigned COLOR_W    = DEF_COLOR_W,
  parameter int unsigned SCORE_W    = DEF_SCORE_W,
  parameter int unsigned HIT_WIN    = DEF_HIT_WIN,
  parameter int unsigned FLOOR_Y    = DEF_FLOOR_Y,
  parameter int unsigned START_Y    = DEF_START_Y,
  parameter int unsigned BOUNCE_LEN = DEF_BOUNCE_LEN
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           step,
  input  logic [NUM_LANES-1:0]           keys_n,
  input  logic [NUM_LANES*POS_W-1:0]     plat_pos,
  input  logic [NUM_LANES*COLOR_W-1:0]   rnd_plats,
  input  logic [COLOR_W-1:0]             rnd_ball,
  output logic [POS_W-1:0]               ball_y,
  output logic [POS_W-1:0]               prev_ball_y,
  output logic [COLOR_W-1:0]             ball_color,
  output logic [NUM_LANES*COLOR_W-1:0]   plat_color,
  output logic [SCORE_W-1:0]             score,
  output logic [SCORE_W-1:0]             high_score,
  output logic                           gameover,
  output logic                           hit,
  output logic                           upd_valid
);

  localparam int unsigned WIDE_W = POS_W + 1;
  localparam int unsigned CNT_W  = (BOUNCE_LEN > 0) ? $clog2(BOUNCE_LEN + 1) : 1;

  state_t                         state, state_n;
  logic [NUM_LANES-1:0]           key_q, pend, pend_n, edges, eff, lane_match;
  logic [CNT_W-1:0]               cnt, cnt_n;
  logic [POS_W-1:0]               ball_y_n, prev_ball_y_n;
  logic [COLOR_W-1:0]             ball_color_n;
  logic [NUM_LANES*COLOR_W-1:0]   plat_color_n;
  logic [SCORE_W-1:0]             score_n, high_score_n;
  logic                           hit_n, upd_n;
  logic [WIDE_W-1:0]              new_y;

  // One comparator per lane against the current ball.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_hit_check #(
      .POS_W   (POS_W),
      .COLOR_W (COLOR_W),
      .HIT_WIN (HIT_WIN)
    ) u_hit (
      .ball_y     (ball_y),
      .ball_color (ball_color),
      .plat_pos   (plat_pos[i*POS_W +: POS_W]),
      .plat_color (plat_color[i*COLOR_W +: COLOR_W]),
      .match_c    (lane_match[i])
    );
  end

  assign edges    = key_q & ~keys_n;
  assign eff      = pend | edges;
  assign gameover = (state == OVER);

  // Next-state and next-value logic for the whole game datapath.
  always_comb begin
    state_n       = state;
    pend_n        = pend | edges;
    cnt_n         = cnt;
    ball_y_n      = ball_y;
    prev_ball_y_n = prev_ball_y;
    ball_color_n  = ball_color;
    plat_color_n  = plat_color;
    score_n       = score;
    high_score_n  = high_score;
    hit_n         = 1'b0;
    upd_n         = 1'b0;
    new_y         = {1'b0, ball_y};

    if (step) pend_n = '0;

    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n       = FALL;
          pend_n        = '0;
          ball_y_n      = POS_W'(START_Y);
          prev_ball_y_n = POS_W'(START_Y);
          score_n       = '0;
          ball_color_n  = rnd_ball;
          plat_color_n  = rnd_plats;
          upd_n         = 1'b1;
        end
      end
      FALL, RISE: begin
        if (step) begin
          upd_n         = 1'b1;
          prev_ball_y_n = ball_y;
          if (state == FALL && $onehot(eff) && |(eff & lane_match)) begin
            // A catch turns the ball around on this very frame.
            hit_n        = 1'b1;
            state_n      = RISE;
            cnt_n        = CNT_W'(BOUNCE_LEN);
            ball_color_n = rnd_ball;
            plat_color_n = rnd_plats;
            score_n      = (score == '1) ? score : score + SCORE_W'(1);
            new_y        = (ball_y == '0) ? '0 : {1'b0, ball_y} - WIDE_W'(1);
          end else if (state == FALL) begin
            new_y = {1'b0, ball_y} + WIDE_W'(1);
          end else begin
            new_y   = (ball_y == '0) ? '0 : {1'b0, ball_y} - WIDE_W'(1);
            cnt_n   = (cnt == '0) ? '0 : cnt - CNT_W'(1);
            if (cnt_n == '0) state_n = FALL;
          end
          ball_y_n = POS_W'(new_y);
          if (new_y >= WIDE_W'(FLOOR_Y)) begin
            state_n      = OVER;
            high_score_n = (score_n > high_score) ? score_n : high_score;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset discards the whole game.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      key_q       <= '1;
      pend        <= '0;
      cnt         <= '0;
      ball_y      <= '0;
      prev_ball_y <= '0;
      ball_color  <= '0;
      plat_color  <= '0;
      score       <= '0;
      high_score  <= '0;
      hit         <= 1'b0;
      upd_valid   <= 1'b0;
    end else begin
      state       <= state_n;
      key_q       <= keys_n;
      pend        <= pend_n;
      cnt         <= cnt_n;
      ball_y      <= ball_y_n;
      prev_ball_y <= prev_ball_y_n;
      ball_color  <= ball_color_n;
      plat_color  <= plat_color_n;
      score       <= score_n;
      high_score  <= high_score_n;
      hit         <= hit_n;
      upd_valid   <= upd_n;
    end
  end

endmodule

// File: tb/tb_lane_bounce_engine.sv
// Directed bench for lane_bounce_engine with hand-computed expectations.
module tb_lane_bounce_engine;

  localparam int unsigned NL = 4;
  localparam int unsigned PW = 7;
  localparam int unsigned CW = 3;
  localparam int unsigned SW = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start, step;
  logic [NL-1:0]     keys_n;
  logic [NL*PW-1:0]  plat_pos;
  logic [NL*CW-1:0]  rnd_plats;
  logic [CW-1:0]     rnd_ball;
  logic [PW-1:0]     ball_y, prev_ball_y;
  logic [CW-1:0]     ball_color;
  logic [NL*CW-1:0]  plat_color;
  logic [SW-1:0]     score, high_score;
  logic              gameover, hit, upd_valid;

  int n_vec = 0;
  int n_bad = 0;
  logic [NL*CW-1:0] exp_plats;

  lane_bounce_engine dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .step        (step),
    .keys_n      (keys_n),
    .plat_pos    (plat_pos),
    .rnd_plats   (rnd_plats),
    .rnd_ball    (rnd_ball),
    .ball_y      (ball_y),
    .prev_ball_y (prev_ball_y),
    .ball_color  (ball_color),
    .plat_color  (plat_color),
    .score       (score),
    .high_score  (high_score),
    .gameover    (gameover),
    .hit         (hit),
    .upd_valid   (upd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input logic [NL-1:0] k);
    keys_n = k;
    step   = 1'b1;
    tick();
    step   = 1'b0;
    keys_n = '1;
  endtask

  task automatic press(input logic [NL-1:0] k);
    keys_n = k;
    tick();
    keys_n = '1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    step      = 1'b0;
    keys_n    = '1;
    plat_pos  = {4{7'd12}};
    rnd_ball  = 3'd5;
    rnd_plats = {3'd5, 3'd5, 3'd5, 3'd2};
    exp_plats = {3'd5, 3'd5, 3'd5, 3'd2};
    tick();
    tick();
    chk("rst_ball_y", 32'(ball_y), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_gameover", 32'(gameover), 0);
    chk("rst_upd", 32'(upd_valid), 0);
    resetn = 1'b1;
    tick();

    // start loads the game
    do_start();
    chk("start_ball_y", 32'(ball_y), 0);
    chk("start_score", 32'(score), 0);
    chk("start_color", 32'(ball_color), 5);
    chk("start_plats", 32'(plat_color), 32'(exp_plats));
    chk("start_upd", 32'(upd_valid), 1);
    tick();
    chk("upd_pulse", 32'(upd_valid), 0);

    // fall to y=9
    for (int i = 0; i < 9; i++) do_step('1);
    chk("fall_y9", 32'(ball_y), 9);
    chk("fall_prev8", 32'(prev_ball_y), 8);

    // two lanes pending -> miss
    press(4'b0101);
    do_step('1);
    chk("multi_hit", 32'(hit), 0);
    chk("multi_y", 32'(ball_y), 10);
    chk("multi_score", 32'(score), 0);

    // lane 2 catch at y=10, platform 12
    rnd_ball  = 3'd1;
    rnd_plats = {3'd1, 3'd4, 3'd1, 3'd7};
    exp_plats = {3'd1, 3'd4, 3'd1, 3'd7};
    press(4'b1011);
    do_step('1);
    chk("hit_pulse", 32'(hit), 1);
    chk("hit_score", 32'(score), 1);
    chk("hit_y", 32'(ball_y), 9);
    chk("hit_prev", 32'(prev_ball_y), 10);
    chk("hit_color", 32'(ball_color), 1);
    chk("hit_plats", 32'(plat_color), 32'(exp_plats));

    // matching key during rise is ignored
    do_step(4'b1101);
    chk("rise_nohit", 32'(hit), 0);
    chk("rise_y", 32'(ball_y), 8);
    for (int i = 0; i < 49; i++) do_step('1);
    chk("rise_end_y", 32'(ball_y), 0);
    chk("rise_end_score", 32'(score), 1);
    do_step('1);
    chk("fall_again", 32'(ball_y), 1);

    // press edge in the step cycle counts
    plat_pos[1*PW +: PW] = 7'd3;
    do_step(4'b1101);
    chk("same_cyc_hit", 32'(hit), 1);
    chk("same_cyc_score", 32'(score), 2);
    chk("same_cyc_y", 32'(ball_y), 0);
    for (int i = 0; i < 50; i++) do_step('1);
    for (int i = 0; i < 115; i++) do_step('1);
    chk("pre_floor_y", 32'(ball_y), 115);
    chk("pre_floor_go", 32'(gameover), 0);

    // floor -> game over
    do_step('1);
    chk("over_go", 32'(gameover), 1);
    chk("over_score", 32'(score), 2);
    chk("over_high", 32'(high_score), 2);
    chk("over_upd", 32'(upd_valid), 1);
    do_step('1);
    chk("over_ignore_upd", 32'(upd_valid), 0);
    chk("over_ignore_y", 32'(ball_y), 116);

    // restart keeps high score
    rnd_ball  = 3'd6;
    rnd_plats = {4{3'd6}};
    do_start();
    chk("restart_y", 32'(ball_y), 0);
    chk("restart_score", 32'(score), 0);
    chk("restart_high", 32'(high_score), 2);
    chk("restart_go", 32'(gameover), 0);
    chk("restart_color", 32'(ball_color), 6);

    // hit, then reset mid-rise
    plat_pos = {4{7'd2}};
    do_step('1);
    do_step(4'b1110);
    chk("hit2", 32'(hit), 1);
    chk("hit2_score", 32'(score), 1);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_y", 32'(ball_y), 0);
    chk("async_score", 32'(score), 0);
    chk("async_high", 32'(high_score), 0);
    chk("async_color", 32'(ball_color), 0);
    chk("async_plats", 32'(plat_color), 0);
    chk("async_hit", 32'(hit), 0);
    tick();
    resetn = 1'b1;
    tick();
    do_step('1);
    chk("idle_step_upd", 32'(upd_valid), 0);
    chk("idle_step_y", 32'(ball_y), 0);
    do_start();
    chk("post_rst_start", 32'(upd_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
